// File: rtl/cbus_rr_arbiter_pkg.sv
// Shared cbus types, length/size encodings and arbiter constants.
// Optional macro honoured by the arbiter: CBUS_ARB_ADDR_XLATE_EN.
package cbus_rr_arbiter_pkg;

    localparam int ARB_NUM_PORTS = 4;

    typedef enum logic [3:0] {
        MLEN1  = 4'b0000,
        MLEN2  = 4'b0001,
        MLEN4  = 4'b0011,
        MLEN8  = 4'b0111,
        MLEN16 = 4'b1111
    } cbus_len_t;

    typedef enum logic [2:0] {
        MSIZE1 = 3'b000,
        MSIZE2 = 3'b001,
        MSIZE4 = 3'b010,
        MSIZE8 = 3'b011
    } cbus_size_t;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        cbus_size_t  size;
        logic [31:0] addr;
        logic [7:0]  strobe;
        logic [63:0] data;
        cbus_len_t   len;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [63:0] data;
    } cbus_resp_t;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

endpackage

// File: rtl/cbus_rr_arbiter_pick.sv
// Round-robin winner search: first valid port at or after ptr, wrapping.
// Purely combinational; reusable by other cbus arbiters.
module rr_pick #(
    parameter  int NUM_PORTS = 4,
    localparam int IDX_W     = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] valid,
    input  logic [IDX_W-1:0]     ptr,
    output logic                 any_valid,
    output logic [IDX_W-1:0]     winner
);

    int               j;
    logic [IDX_W-1:0] idx;

    // Scan from farthest to nearest so the port nearest ptr overwrites last.
    always_comb begin
        any_valid = 1'b0;
        winner    = '0;
        j         = 0;
        idx       = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            j = int'(ptr) + i;
            if (j >= NUM_PORTS) begin
                j = j - NUM_PORTS;
            end
            idx = IDX_W'(j);
            if (valid[idx]) begin
                any_valid = 1'b1;
                winner    = idx;
            end
        end
    end

endmodule

// File: rtl/cbus_rr_arbiter.sv
// Round-robin cbus arbiter: one burst at a time, grant held to last beat.
// Macro CBUS_ARB_ADDR_XLATE_EN maps kseg0/kseg1 to physical on oreq.addr.
module cbus_rr_arbiter
    import cbus_rr_arbiter_pkg::*;
#(
    parameter  int NUM_PORTS = ARB_NUM_PORTS,
    localparam int IDX_W     = $clog2(NUM_PORTS)
) (
    input  logic       clk,
    input  logic       resetn,
    input  cbus_req_t  ireqs  [NUM_PORTS],
    output cbus_resp_t iresps [NUM_PORTS],
    output cbus_req_t  oreq,
    input  cbus_resp_t oresp
);

    arb_state_t           state_q, state_d;
    logic [IDX_W-1:0]     grant_q, grant_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [NUM_PORTS-1:0] valid_vec;
    logic                 any_valid;
    logic [IDX_W-1:0]     winner;
    logic                 done;

    always_comb begin
        valid_vec = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            valid_vec[i] = ireqs[i].valid;
        end
    end

    rr_pick #(
        .NUM_PORTS (NUM_PORTS)
    ) u_pick (
        .valid     (valid_vec),
        .ptr       (ptr_q),
        .any_valid (any_valid),
        .winner    (winner)
    );

    assign done = oresp.ready && oresp.last;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (any_valid) begin
                    state_d = ARB_BUSY;
                    grant_d = winner;
                end
            end
            ARB_BUSY: begin
                if (done) begin
                    state_d = ARB_IDLE;
                    if (grant_q == IDX_W'(NUM_PORTS - 1)) begin
                        ptr_d = '0;
                    end else begin
                        ptr_d = grant_q + 1'b1;
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // Grant is held even if the master drops valid; oreq just follows it.
    always_comb begin
        oreq = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            iresps[i] = '0;
        end
        if (state_q == ARB_BUSY) begin
            oreq = ireqs[grant_q];
`ifdef CBUS_ARB_ADDR_XLATE_EN
            if (ireqs[grant_q].addr[31:30] == 2'b10) begin
                oreq.addr[31:29] = 3'b000;
            end
`endif
            iresps[grant_q] = oresp;
        end
    end

endmodule

// File: tb/tb_cbus_rr_arbiter.sv
// Directed self-checking bench for cbus_rr_arbiter.
// Address expectations follow CBUS_ARB_ADDR_XLATE_EN when defined.
module tb_cbus_rr_arbiter;
    import cbus_rr_arbiter_pkg::*;

    localparam int N = ARB_NUM_PORTS;

`ifdef CBUS_ARB_ADDR_XLATE_EN
    localparam logic [31:0] XA_BFC = 32'h1FC0_0000;
    localparam logic [31:0] XA_800 = 32'h0000_1000;
    localparam logic [31:0] XA_A00 = 32'h0000_0000;
`else
    localparam logic [31:0] XA_BFC = 32'hBFC0_0000;
    localparam logic [31:0] XA_800 = 32'h8000_1000;
    localparam logic [31:0] XA_A00 = 32'hA000_0000;
`endif

    logic       clk = 1'b0;
    logic       resetn;
    cbus_req_t  ireqs  [N];
    cbus_resp_t iresps [N];
    cbus_req_t  oreq;
    cbus_resp_t oresp;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cbus_rr_arbiter dut (
        .clk    (clk),
        .resetn (resetn),
        .ireqs  (ireqs),
        .iresps (iresps),
        .oreq   (oreq),
        .oresp  (oresp)
    );

    function automatic cbus_req_t mk_req(logic [31:0] a, cbus_len_t l);
        cbus_req_t r;
        r        = '0;
        r.valid  = 1'b1;
        r.size   = MSIZE4;
        r.addr   = a;
        r.strobe = 8'h0f;
        r.data   = {32'h0, a};
        r.len    = l;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        for (int i = 0; i < N; i++) ireqs[i] = '0;
        oresp = '0;
    endtask

    task automatic do_reset();
        idle_bus();
        resetn = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        idle_bus();
        ireqs[1]    = mk_req(32'h0000_0100, MLEN4);
        oresp.ready = 1'b1;
        oresp.data  = 64'hdead;
        resetn      = 1'b0;
        tick();
        tick();
        total++;
        if (dut.state_q !== ARB_IDLE) begin
            bad++;
            $display("FAIL reset_state: got %0d want IDLE", dut.state_q);
        end
        total++;
        if (dut.ptr_q !== 2'd0) begin
            bad++;
            $display("FAIL reset_ptr: got %0d want 0", dut.ptr_q);
        end
        total++;
        if (dut.grant_q !== 2'd0) begin
            bad++;
            $display("FAIL reset_grant: got %0d want 0", dut.grant_q);
        end
        total++;
        if (oreq !== '0) begin
            bad++;
            $display("FAIL reset_oreq: got %h want 0", oreq);
        end
        for (int i = 0; i < N; i++) begin
            total++;
            if (iresps[i] !== '0) begin
                bad++;
                $display("FAIL reset_iresp%0d: got %h want 0", i, iresps[i]);
            end
        end
        resetn = 1'b1;
        idle_bus();
    endtask

    task automatic test_single();
        logic        el;
        logic [63:0] ed;
        do_reset();
        ireqs[2] = mk_req(32'h1FC0_0000, MLEN4);
        #1;
        total++;
        if (oreq.valid !== 1'b0) begin
            bad++;
            $display("FAIL single_arb: oreq.valid=%b want 0", oreq.valid);
        end
        tick();
        total++;
        if (oreq.valid !== 1'b1) begin
            bad++;
            $display("FAIL single_valid: oreq.valid=%b want 1", oreq.valid);
        end
        total++;
        if (oreq.addr !== 32'h1FC0_0000) begin
            bad++;
            $display("FAIL single_addr: got %h want 1fc00000", oreq.addr);
        end
        total++;
        if (dut.grant_q !== 2'd2) begin
            bad++;
            $display("FAIL single_grant: got %0d want 2", dut.grant_q);
        end
        for (int b = 1; b <= 4; b++) begin
            el          = (b == 4);
            ed          = 64'hA0 + 64'(b);
            oresp.ready = 1'b1;
            oresp.last  = el;
            oresp.data  = ed;
            #1;
            total++;
            if (iresps[2].ready !== 1'b1 || iresps[2].last !== el ||
                iresps[2].data !== ed) begin
                bad++;
                $display("FAIL single_beat%0d: got %h want r=1 l=%b d=%h",
                         b, iresps[2], el, ed);
            end
            total++;
            if (iresps[0] !== '0) begin
                bad++;
                $display("FAIL single_iso%0d: got %h want 0", b, iresps[0]);
            end
            tick();
        end
        idle_bus();
        #1;
        total++;
        if (dut.state_q !== ARB_IDLE || dut.ptr_q !== 2'd3) begin
            bad++;
            $display("FAIL single_end: st=%0d ptr=%0d want IDLE ptr=3",
                     dut.state_q, dut.ptr_q);
        end
        total++;
        if (oreq !== '0) begin
            bad++;
            $display("FAIL single_oreq_end: got %h want 0", oreq);
        end
    endtask

    task automatic test_all_four();
        int          exp_order [4] = '{0, 1, 2, 3};
        logic [31:0] ea;
        do_reset();
        for (int k = 0; k < N; k++) begin
            ireqs[k] = mk_req(32'h1000 + 32'(k) * 32'h10, MLEN1);
        end
        #1;
        for (int k = 0; k < N; k++) begin
            ea = 32'h1000 + 32'(exp_order[k]) * 32'h10;
            total++;
            if (oreq.valid !== 1'b0) begin
                bad++;
                $display("FAIL four_gap%0d: oreq.valid=%b want 0",
                         k, oreq.valid);
            end
            tick();
            total++;
            if (dut.grant_q !== 2'(exp_order[k]) || oreq.addr !== ea) begin
                bad++;
                $display("FAIL four_grant%0d: g=%0d a=%h want g=%0d a=%h",
                         k, dut.grant_q, oreq.addr, exp_order[k], ea);
            end
            oresp.ready = 1'b1;
            oresp.last  = 1'b1;
            oresp.data  = 64'(k + 7);
            #1;
            total++;
            if (iresps[exp_order[k]].data !== 64'(k + 7) ||
                iresps[exp_order[k]].ready !== 1'b1) begin
                bad++;
                $display("FAIL four_resp%0d: got %h want r=1 d=%0d",
                         k, iresps[exp_order[k]], k + 7);
            end
            tick();
            ireqs[exp_order[k]] = '0;
            oresp = '0;
            #1;
        end
        total++;
        if (dut.ptr_q !== 2'd0) begin
            bad++;
            $display("FAIL four_ptr_wrap: got %0d want 0", dut.ptr_q);
        end
    endtask

    task automatic test_ptr_wrap();
        do_reset();
        ireqs[2] = mk_req(32'h2000, MLEN1);
        tick();
        oresp.ready = 1'b1;
        oresp.last  = 1'b1;
        tick();
        idle_bus();
        ireqs[0] = mk_req(32'h3000, MLEN1);
        ireqs[3] = mk_req(32'h3300, MLEN1);
        #1;
        total++;
        if (dut.ptr_q !== 2'd3) begin
            bad++;
            $display("FAIL wrap_ptr3: got %0d want 3", dut.ptr_q);
        end
        tick();
        total++;
        if (dut.grant_q !== 2'd3 || oreq.addr !== 32'h3300) begin
            bad++;
            $display("FAIL wrap_first: g=%0d a=%h want g=3 a=3300",
                     dut.grant_q, oreq.addr);
        end
        oresp.ready = 1'b1;
        oresp.last  = 1'b1;
        tick();
        ireqs[3] = '0;
        oresp    = '0;
        #1;
        total++;
        if (dut.ptr_q !== 2'd0) begin
            bad++;
            $display("FAIL wrap_ptr0: got %0d want 0", dut.ptr_q);
        end
        tick();
        total++;
        if (dut.grant_q !== 2'd0 || oreq.addr !== 32'h3000) begin
            bad++;
            $display("FAIL wrap_second: g=%0d a=%h want g=0 a=3000",
                     dut.grant_q, oreq.addr);
        end
        oresp.ready = 1'b1;
        oresp.last  = 1'b1;
        tick();
        idle_bus();
        #1;
        total++;
        if (dut.ptr_q !== 2'd1) begin
            bad++;
            $display("FAIL wrap_ptr1: got %0d want 1", dut.ptr_q);
        end
    endtask

    task automatic test_isolation();
        logic [63:0] ed;
        do_reset();
        ireqs[1] = mk_req(32'h4000, MLEN8);
        tick();
        ireqs[0] = mk_req(32'h4400, MLEN1);
        for (int b = 1; b <= 8; b++) begin
            ed          = 64'h100 + 64'(b);
            oresp.ready = (b != 3);
            oresp.last  = (b == 8);
            oresp.data  = ed;
            #1;
            total++;
            if (iresps[0] !== '0) begin
                bad++;
                $display("FAIL iso_p0_beat%0d: got %h want 0", b, iresps[0]);
            end
            total++;
            if (iresps[1].data !== ed || dut.grant_q !== 2'd1) begin
                bad++;
                $display("FAIL iso_p1_beat%0d: d=%h g=%0d want d=%h g=1",
                         b, iresps[1].data, dut.grant_q, ed);
            end
            tick();
        end
        ireqs[1] = '0;
        oresp    = '0;
        #1;
        total++;
        if (dut.state_q !== ARB_IDLE || dut.ptr_q !== 2'd2 ||
            iresps[0] !== '0) begin
            bad++;
            $display("FAIL iso_gap: st=%0d ptr=%0d r0=%h want IDLE 2 0",
                     dut.state_q, dut.ptr_q, iresps[0]);
        end
        tick();
        oresp.ready = 1'b1;
        oresp.last  = 1'b1;
        oresp.data  = 64'h55;
        #1;
        total++;
        if (dut.grant_q !== 2'd0 || iresps[0].data !== 64'h55 ||
            iresps[1] !== '0) begin
            bad++;
            $display("FAIL iso_next: g=%0d r0=%h r1=%h want g=0 d=55",
                     dut.grant_q, iresps[0], iresps[1]);
        end
        tick();
        idle_bus();
    endtask

    task automatic test_reset_mid();
        do_reset();
        ireqs[2] = mk_req(32'h5000, MLEN4);
        tick();
        oresp.ready = 1'b1;
        oresp.data  = 64'h1;
        tick();
        oresp.data = 64'h2;
        resetn     = 1'b0;
        tick();
        total++;
        if (oreq !== '0 || dut.state_q !== ARB_IDLE || dut.ptr_q !== 2'd0) begin
            bad++;
            $display("FAIL rstmid_core: oreq=%h st=%0d ptr=%0d want 0 IDLE 0",
                     oreq, dut.state_q, dut.ptr_q);
        end
        for (int i = 0; i < N; i++) begin
            total++;
            if (iresps[i] !== '0) begin
                bad++;
                $display("FAIL rstmid_iresp%0d: got %h want 0", i, iresps[i]);
            end
        end
        resetn = 1'b1;
        idle_bus();
    endtask

    task automatic test_xlate_drop();
        do_reset();
        ireqs[0] = mk_req(32'hBFC0_0000, MLEN4);
        tick();
        total++;
        if (oreq.addr !== XA_BFC) begin
            bad++;
            $display("FAIL xl_bfc: got %h want %h", oreq.addr, XA_BFC);
        end
        ireqs[0].addr = 32'h8000_1000;
        #1;
        total++;
        if (oreq.addr !== XA_800) begin
            bad++;
            $display("FAIL xl_800: got %h want %h", oreq.addr, XA_800);
        end
        ireqs[0].addr = 32'hA000_0000;
        #1;
        total++;
        if (oreq.addr !== XA_A00) begin
            bad++;
            $display("FAIL xl_a00: got %h want %h", oreq.addr, XA_A00);
        end
        ireqs[0].addr = 32'h0040_0000;
        #1;
        total++;
        if (oreq.addr !== 32'h0040_0000) begin
            bad++;
            $display("FAIL xl_004: got %h want 00400000", oreq.addr);
        end
        ireqs[0].valid = 1'b0;
        #1;
        total++;
        if (oreq.valid !== 1'b0 || dut.state_q !== ARB_BUSY) begin
            bad++;
            $display("FAIL drop_follow: v=%b st=%0d want 0 BUSY",
                     oreq.valid, dut.state_q);
        end
        tick();
        total++;
        if (dut.state_q !== ARB_BUSY || dut.grant_q !== 2'd0) begin
            bad++;
            $display("FAIL drop_hold: st=%0d g=%0d want BUSY 0",
                     dut.state_q, dut.grant_q);
        end
        oresp.ready = 1'b1;
        oresp.last  = 1'b1;
        tick();
        idle_bus();
        #1;
        total++;
        if (dut.state_q !== ARB_IDLE || dut.ptr_q !== 2'd1) begin
            bad++;
            $display("FAIL drop_end: st=%0d ptr=%0d want IDLE 1",
                     dut.state_q, dut.ptr_q);
        end
    endtask

    initial begin
        resetn = 1'b0;
        idle_bus();
        test_reset();
        test_single();
        test_all_four();
        test_ptr_wrap();
        test_isolation();
        test_reset_mid();
        test_xlate_drop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
